// File: rtl/delay_line_pipe_pkg.sv
// Shared defaults for the systolic-array delay lines and a helper used to size
// the tap-select / occupancy width from the pipeline depth.
package delay_line_pipe_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_SEL_W = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Smallest width that can hold every count 0..depth.
  function automatic int sel_width(input int depth);
    int w;
    w = clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/delay_line_pipe_stage.sv
// One register stage of the delay line: data word plus its valid flag.
module delay_line_pipe_stage
  import delay_line_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // Data is cleared with the valid bit so nothing from before reset/flush can leak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (flush) begin
      q       <= '0;
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/delay_line_pipe.sv
// Multi-stage delay line with valid tracking, stall, flush, a runtime tap mux
// and an occupancy counter of valid entries held in the pipeline.
module delay_line_pipe
  import delay_line_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic [SEL_W-1:0] tap_sel,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [SEL_W-1:0] occ
);

  logic [WIDTH-1:0] sd [1:DEPTH];
  logic             sv [1:DEPTH];
  logic [SEL_W-1:0] tap;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    if (k == 1) begin : g_head
      delay_line_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .d       (d),
        .d_valid (d_valid),
        .q       (sd[k]),
        .q_valid (sv[k])
      );
    end else begin : g_body
      delay_line_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .d       (sd[k-1]),
        .d_valid (sv[k-1]),
        .q       (sd[k]),
        .q_valid (sv[k])
      );
    end
  end

  // Tap 0 means the first stage; anything past the end clamps to the last stage.
  always_comb begin
    tap = tap_sel;
    if (tap_sel == '0)
      tap = SEL_W'(1);
    else if (tap_sel > SEL_W'(DEPTH))
      tap = SEL_W'(DEPTH);
  end

  // Mux purely from stage registers, so d never reaches q combinationally.
  always_comb begin
    q       = sd[1];
    q_valid = sv[1];
    for (int k = 2; k <= DEPTH; k++) begin
      if (tap == SEL_W'(k)) begin
        q       = sd[k];
        q_valid = sv[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      occ <= '0;
    else if (flush)
      occ <= '0;
    else if (en)
      occ <= occ + SEL_W'(d_valid) - SEL_W'(sv[DEPTH]);
  end

  a_occ_bound: assert property (@(posedge clk) disable iff (rst) occ <= SEL_W'(DEPTH));

endmodule

// File: doc/delay_line_pipe.md
Name: delay_line_pipe

Overview:
- Parametrised multi-bit, multi-stage delay line with valid tracking, stall, flush and a runtime-selectable output tap.
- Successor to the single-bit registered delay used between systolic PEs of the finite-field multiplier.
- Aligns operand/partial-product buses that must skew by a varying number of cycles across the array.
- Replaces chains of hand-instantiated 1-bit delays.

Parameters:
- WIDTH, 8: data bits per stage (>=1).
- DEPTH, 4: number of register stages (>=1).
- SEL_W, 3: width of tap select and occupancy count; must satisfy 2**SEL_W > DEPTH.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: reset; asynchronous, active-high.
- en, input, 1: advance enable; 0 = all stages hold.
- flush, input, 1: synchronous clear of all stages.
- d, input, WIDTH: data in.
- d_valid, input, 1: qualifies d.
- tap_sel, input, SEL_W: requested delay in cycles of en.
- q, output, WIDTH: data at the selected tap.
- q_valid, output, 1: valid at the selected tap.
- occ, output, SEL_W: number of valid entries across all DEPTH stages.

Behaviour:
- Reset (rst=1, async): every stage data = 0, stage valid = 0, occ = 0. Hence q = 0 and q_valid = 0 immediately, independent of clk.
- Stages are s[1]..s[DEPTH]; each holds {data, valid}.
- Priority at each posedge: rst > flush > en.
- flush=1: all stages data = 0, valid = 0; occ = 0 next cycle. The d/d_valid presented that cycle is discarded, regardless of en.
- en=1, flush=0: s[1] <= {d, d_valid}; s[k] <= s[k-1] for k = 2..DEPTH; s[DEPTH]'s old contents are dropped.
- en=0, flush=0: all stages and occ hold.
- Invalid entries: d is still captured when d_valid=0 (no gating). Data of invalid entries is don't-care to consumers. Verification checks q only when q_valid=1.
- Effective tap t:
  - t = 1 if tap_sel = 0.
  - t = DEPTH if tap_sel > DEPTH.
  - otherwise t = tap_sel.
- q/q_valid = s[t]. This is a combinational mux from registers only; no path from d to q.
- Latency: with en held 1, a sample with d_valid=1 at edge n appears at q with q_valid=1 after edge n+t-1, i.e. visible in cycle n+t−1..n+t window per standard register timing (t edges total). Stall cycles (en=0) add one cycle each.
- tap_sel may change any cycle. Output switches to the new tap in the same cycle. Stage contents are not disturbed; samples may be skipped or repeated, and this is legal.
- occ update on each enabled, non-flush edge: occ_next = occ + d_valid − s[DEPTH].valid. Simultaneous enter+leave leaves occ unchanged. occ never exceeds DEPTH; an assertion flags violation.
- Reset deasserting mid-stream: the pipeline restarts empty. No sample issued before reset may ever appear at q.
- DEPTH=1: single stage; tap_sel is ignored, effectively t=1.

Decomposition:
- Shared header ff_sys_defs.vh:
  - default WIDTH/DEPTH constants for the 8-bit array;
  - a clog2 constant function used to size SEL_W at instantiation.
- Sub-module delay_stage (one stage):
  - WIDTH data register plus valid bit;
  - inputs clk, rst, en, flush, d, d_valid; outputs q, q_valid;
  - generated DEPTH times.
- Tap mux and occ counter stay in the top module.

Test Plan:
- Reset: assert rst between edges with stages full → q=0, q_valid=0, occ=0 before the next edge. Deassert, send 8'hA5 (d_valid=1), tap_sel=4 → q=8'hA5, q_valid=1 exactly 4 enabled edges later.
- Streaming: WIDTH=8, DEPTH=4, tap_sel=2, en=1, feed 8'h01,8'h02,8'h03… valid → q shows 8'h01 after edge 2, then one increment per cycle. occ rises 1,2,3,4 and stays 4.
- Stall: after 8'h10 enters, hold en=0 for 3 cycles, tap_sel=3 → q/occ frozen during stall; 8'h10 emerges 3 enabled edges after entry (6 total cycles).
- Flush: occ=4, assert flush with en=1, d=8'hFF, d_valid=1 → next cycle occ=0, q_valid=0 at every tap. 8'hFF never appears.
- Tap clamping/switching: with stages holding 11,22,33,44 (s1..s4): tap_sel=0 → q=11; tap_sel=7 → q=44; switch 2→4 → q changes 22→44 in the same cycle.
- Occupancy balance: alternate d_valid 1,0 continuously → occ settles at 2. Single valid entering while the last valid leaves on the same edge → occ unchanged.
